alu_wb_buffer: RTL and testbench
================================

# alu_wb_buffer

Result buffer between the two ALU issue slots (U and V) and the register-file write ports. Each cycle it captures the pair of `uv_buff_t` packages produced by the ALUs and orders them oldest/youngest using `is_instr2`. It queues the pairs in a small FIFO so that writeback can stall without stalling execution, retires one pair per cycle over two write ports, and serves a two-port forwarding lookup over all buffered results.

## Interface
- `DEPTH`, default 4: number of pair entries. Must be a power of 2 and at least 2.
- `i_clk`, in, 1: clock. All state updates on the rising edge.
- `i_rst`, in, 1: reset. Synchronous, active-high.
- `i_flush`, in, 1: discard all buffered and incoming results (wrong path).
- `i_u_pkg`, in, `uv_buff_t`: U-slot ALU result (`data_buff`, `rd_buff`, `wr_en`, `valid`, `is_instr2`).
- `i_v_pkg`, in, `uv_buff_t`: V-slot ALU result, same fields.
- `o_buff_ready`, out, 1: buffer can accept a pair this cycle.
- `i_wb_ready`, in, 1: writeback accepts the head pair this cycle.
- `o_wb_valid`, out, 1: head pair present.
- `o_wb_en0`, out, 1: older write-port enable.
- `o_wb_rd0`, out, 5: older write-port register index.
- `o_wb_data0`, out, 32: older write-port data.
- `o_wb_en1`, out, 1: younger write-port enable.
- `o_wb_rd1`, out, 5: younger write-port register index.
- `o_wb_data1`, out, 32: younger write-port data.
- `i_fwd_rs_a`, in, 5: forwarding lookup address, port A.
- `i_fwd_rs_b`, in, 5: forwarding lookup address, port B.
- `o_fwd_hit_a`, out, 1: lookup hit, port A.
- `o_fwd_data_a`, out, 32: forwarded data, port A.
- `o_fwd_hit_b`, out, 1: lookup hit, port B.
- `o_fwd_data_b`, out, 32: forwarded data, port B.
- `o_count`, out, `$clog2(DEPTH)+1`: number of occupied entries.

## Operation
- **Push condition:** `(i_u_pkg.valid | i_v_pkg.valid) & o_buff_ready & ~i_flush`. A cycle with neither slot valid never allocates an entry.
- **Slot ordering:** the U slot is older. The exception is `i_u_pkg.is_instr2=1` together with `i_v_pkg.is_instr2=0`, in which case the slots swap. Each stored slot keeps its own valid, `wr_en`, `rd` and `data`.
- **Single valid slot:** when only one slot is valid, it is stored in its ordered position and the other position is marked invalid.
- **Entries without writes:** an entry whose slots have `wr_en=0` still occupies the buffer and retires normally, with no register write.
- **`o_buff_ready`:** equals `~full`. It is computed from registered count only; there is no pass-through when a pop happens in the same cycle.
- **Pop condition:** `o_wb_valid & i_wb_ready`. Pointers wrap modulo `DEPTH`.
- **Head outputs:** `o_wb_*` are driven combinationally from the head entry. A port enable is `slot_valid & wr_en & (rd != 0)`.
- **Write collision:** if both enables would be 1 and `rd0 == rd1`, `o_wb_en0` is forced to 0, so the younger write wins.
- **Empty buffer:** `o_wb_valid=0`, both enables 0, `rd`/`data` driven to 0.
- **Forwarding:** each lookup port searches all occupied entries for a slot with `valid & wr_en & rd == rs`.
  - Priority is youngest entry first, and within an entry slot1 before slot0.
  - `rs == 0` never hits.
  - On a miss, hit = 0 and data = 0.
  - Incoming, not-yet-stored packages are not searched.
- **Flush:** `i_flush` empties the buffer on the next edge (pointers and count to 0) and drops any push in the same cycle. Flush takes priority over push and pop. A pop handshake asserted in the flush cycle still counts as completed by writeback.
- **Reset:** `i_rst` has the same effect as flush and has priority over everything.

## Timing
- **Reset values** (valid on the first cycle after `i_rst` is sampled high):
  - `o_count=0`, `o_buff_ready=1`, `o_wb_valid=0`.
  - `o_wb_en0=o_wb_en1=0`, `o_wb_rd0=o_wb_rd1=0`, `o_wb_data0=o_wb_data1=0`.
  - `o_fwd_hit_a=o_fwd_hit_b=0`, `o_fwd_data_a=o_fwd_data_b=0`.
- **Latency:** a pair pushed at edge N appears at the head and in forwarding from cycle N+1 (1 cycle, empty buffer).
- **Throughput:** 1 pair per cycle in and out. A simultaneous push and pop when not full leaves count unchanged.
- **Full:** `o_buff_ready=0`. Upstream holds its packages; the buffer ignores them even if valid.
- **Other outputs:** forwarding and `o_wb_*` are purely combinational from state and lookup inputs; no input-to-output path exists except the lookup addresses.

## Test plan
- **Single push/pop:** after reset, push U={valid=1, wr_en=1, rd=5, data=0x11}, V={valid=1, wr_en=1, rd=6, data=0x22, is_instr2=1}, with `i_wb_ready=1`.
  - Next cycle: `o_wb_en0=1` rd0=5 data0=0x11, `o_wb_en1=1` rd1=6 data1=0x22.
  - Following cycle: `o_wb_valid=0`.
- **Swap and collision:** push U={is_instr2=1, rd=7, data=0xA}, V={is_instr2=0, rd=7, data=0xB}.
  - Head shows rd1=7, data1=0xA, `o_wb_en1=1`, and `o_wb_en0=0`.
- **Fill and stall:** hold `i_wb_ready=0` and push 5 pairs.
  - `o_count` goes 1..4, `o_buff_ready=0` after the 4th, and the 5th is not stored.
  - Release `i_wb_ready`: the pairs retire in push order over 4 cycles.
- **Forwarding priority:** buffer entry0 = {rd=3, 0x100}, entry1 = {slot0 rd=3 0x200, slot1 rd=3 0x300}, `i_fwd_rs_a=3` -> hit, 0x300.
  - `i_fwd_rs_b=0` with an entry writing rd=0 -> hit=0.
- **Flush during push:** with 2 entries stored, assert `i_flush` while pushing a valid pair.
  - Next cycle: `o_count=0`, `o_wb_valid=0`, no forwarding hits.
- **Reset mid-operation:** with 3 entries stored and `i_wb_ready=1`, assert `i_rst` for 1 cycle.
  - Next cycle all outputs are at their reset values and `o_buff_ready=1`.

Source files
------------

// File: rtl/alu_wb_buffer.sv
`default_nettype none
// ============================================================================
// alu_wb_buffer : ordered U/V result FIFO feeding two register-file write ports
// Revision 1.0
// ============================================================================

package alu_wb_pkg;
  typedef struct packed {
    logic [31:0] data_buff;
    logic [4:0]  rd_buff;
    logic        wr_en;
    logic        valid;
    logic        is_instr2;
  } uv_buff_t;
endpackage

module alu_wb_buffer
  import alu_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  uv_buff_t                 i_u_pkg,
  input  uv_buff_t                 i_v_pkg,
  output logic                     o_buff_ready,
  input  logic                     i_wb_ready,
  output logic                     o_wb_valid,
  output logic                     o_wb_en0,
  output logic [4:0]               o_wb_rd0,
  output logic [31:0]              o_wb_data0,
  output logic                     o_wb_en1,
  output logic [4:0]               o_wb_rd1,
  output logic [31:0]              o_wb_data1,
  input  logic [4:0]               i_fwd_rs_a,
  input  logic [4:0]               i_fwd_rs_b,
  output logic                     o_fwd_hit_a,
  output logic [31:0]              o_fwd_data_a,
  output logic                     o_fwd_hit_b,
  output logic [31:0]              o_fwd_data_b,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic        valid;
    logic        wr_en;
    logic [4:0]  rd;
    logic [31:0] data;
  } slot_t;

  slot_t          old_q [DEPTH];
  slot_t          yng_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;

  logic  w_full, w_push, w_pop, w_swap;
  slot_t w_old, w_yng, w_head0, w_head1;

  assign w_full       = (count_q == (AW+1)'(DEPTH));
  assign o_buff_ready = ~w_full;
  assign o_wb_valid   = (count_q != '0);
  assign w_push       = (i_u_pkg.valid | i_v_pkg.valid) & ~w_full & ~i_flush;
  assign w_pop        = o_wb_valid & i_wb_ready;
  assign o_count      = count_q;

  // U is the older slot unless U is flagged as the second instruction and V is not.
  assign w_swap = i_u_pkg.is_instr2 & ~i_v_pkg.is_instr2;

  always_comb begin
    w_old = '0;
    w_yng = '0;
    if (w_swap) begin
      w_old = '{i_v_pkg.valid, i_v_pkg.wr_en, i_v_pkg.rd_buff, i_v_pkg.data_buff};
      w_yng = '{i_u_pkg.valid, i_u_pkg.wr_en, i_u_pkg.rd_buff, i_u_pkg.data_buff};
    end else begin
      w_old = '{i_u_pkg.valid, i_u_pkg.wr_en, i_u_pkg.rd_buff, i_u_pkg.data_buff};
      w_yng = '{i_v_pkg.valid, i_v_pkg.wr_en, i_v_pkg.rd_buff, i_v_pkg.data_buff};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      old_q[wr_ptr_q] <= w_old;
      yng_q[wr_ptr_q] <= w_yng;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst | i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head outputs; on a same-register collision the younger write wins.
  always_comb begin
    w_head0    = '0;
    w_head1    = '0;
    o_wb_en0   = 1'b0;
    o_wb_en1   = 1'b0;
    o_wb_rd0   = '0;
    o_wb_rd1   = '0;
    o_wb_data0 = '0;
    o_wb_data1 = '0;
    if (o_wb_valid) begin
      w_head0    = old_q[rd_ptr_q];
      w_head1    = yng_q[rd_ptr_q];
      o_wb_en0   = w_head0.valid & w_head0.wr_en & (w_head0.rd != 5'd0);
      o_wb_en1   = w_head1.valid & w_head1.wr_en & (w_head1.rd != 5'd0);
      if (o_wb_en0 & o_wb_en1 & (w_head0.rd == w_head1.rd)) o_wb_en0 = 1'b0;
      o_wb_rd0   = w_head0.rd;
      o_wb_rd1   = w_head1.rd;
      o_wb_data0 = w_head0.data;
      o_wb_data1 = w_head1.data;
    end
  end

  // Walk oldest to youngest so later matches override earlier ones.
  always_comb begin
    logic [AW-1:0] idx;
    idx          = '0;
    o_fwd_hit_a  = 1'b0;
    o_fwd_data_a = '0;
    o_fwd_hit_b  = 1'b0;
    o_fwd_data_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((AW+1)'(k) < count_q) begin
        idx = rd_ptr_q + AW'(k);
        if (i_fwd_rs_a != 5'd0) begin
          if (old_q[idx].valid & old_q[idx].wr_en & (old_q[idx].rd == i_fwd_rs_a)) begin
            o_fwd_hit_a  = 1'b1;
            o_fwd_data_a = old_q[idx].data;
          end
          if (yng_q[idx].valid & yng_q[idx].wr_en & (yng_q[idx].rd == i_fwd_rs_a)) begin
            o_fwd_hit_a  = 1'b1;
            o_fwd_data_a = yng_q[idx].data;
          end
        end
        if (i_fwd_rs_b != 5'd0) begin
          if (old_q[idx].valid & old_q[idx].wr_en & (old_q[idx].rd == i_fwd_rs_b)) begin
            o_fwd_hit_b  = 1'b1;
            o_fwd_data_b = old_q[idx].data;
          end
          if (yng_q[idx].valid & yng_q[idx].wr_en & (yng_q[idx].rd == i_fwd_rs_b)) begin
            o_fwd_hit_b  = 1'b1;
            o_fwd_data_b = yng_q[idx].data;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_wb_buffer.sv
`default_nettype none
// ============================================================================
// tb_alu_wb_buffer : scoreboard bench for alu_wb_buffer
// Revision 1.0
// ============================================================================
module tb_alu_wb_buffer;
  import alu_wb_pkg::*;

  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst, i_flush, i_wb_ready;
  uv_buff_t    i_u_pkg, i_v_pkg;
  logic        o_buff_ready, o_wb_valid;
  logic        o_wb_en0, o_wb_en1;
  logic [4:0]  o_wb_rd0, o_wb_rd1, i_fwd_rs_a, i_fwd_rs_b;
  logic [31:0] o_wb_data0, o_wb_data1, o_fwd_data_a, o_fwd_data_b;
  logic        o_fwd_hit_a, o_fwd_hit_b;
  logic [$clog2(DEPTH):0] o_count;

  alu_wb_buffer #(.DEPTH(DEPTH)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_u_pkg(i_u_pkg), .i_v_pkg(i_v_pkg), .o_buff_ready(o_buff_ready),
    .i_wb_ready(i_wb_ready), .o_wb_valid(o_wb_valid),
    .o_wb_en0(o_wb_en0), .o_wb_rd0(o_wb_rd0), .o_wb_data0(o_wb_data0),
    .o_wb_en1(o_wb_en1), .o_wb_rd1(o_wb_rd1), .o_wb_data1(o_wb_data1),
    .i_fwd_rs_a(i_fwd_rs_a), .i_fwd_rs_b(i_fwd_rs_b),
    .o_fwd_hit_a(o_fwd_hit_a), .o_fwd_data_a(o_fwd_data_a),
    .o_fwd_hit_b(o_fwd_hit_b), .o_fwd_data_b(o_fwd_data_b),
    .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        v0, we0; logic [4:0] rd0; logic [31:0] d0;
    logic        v1, we1; logic [4:0] rd1; logic [31:0] d1;
  } ent_t;

  ent_t sb[$];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic uv_buff_t mk(input logic v, input logic we, input logic [4:0] rd,
                                  input logic [31:0] d, input logic i2);
    uv_buff_t p;
    p.valid = v; p.wr_en = we; p.rd_buff = rd; p.data_buff = d; p.is_instr2 = i2;
    return p;
  endfunction

  function automatic ent_t order(input uv_buff_t u, input uv_buff_t v);
    ent_t e;
    uv_buff_t o, y;
    if (u.is_instr2 && !v.is_instr2) begin o = v; y = u; end
    else begin o = u; y = v; end
    e.v0 = o.valid; e.we0 = o.wr_en; e.rd0 = o.rd_buff; e.d0 = o.data_buff;
    e.v1 = y.valid; e.we1 = y.wr_en; e.rd1 = y.rd_buff; e.d1 = y.data_buff;
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    logic en0, en1, ha, hb;
    logic [4:0] rd0, rd1;
    logic [31:0] d0, d1, da, db;
    en0 = 0; en1 = 0; rd0 = 0; rd1 = 0; d0 = 0; d1 = 0;
    if (sb.size() > 0) begin
      en0 = sb[0].v0 & sb[0].we0 & (sb[0].rd0 != 0);
      en1 = sb[0].v1 & sb[0].we1 & (sb[0].rd1 != 0);
      if (en0 && en1 && sb[0].rd0 == sb[0].rd1) en0 = 0;
      rd0 = sb[0].rd0; rd1 = sb[0].rd1; d0 = sb[0].d0; d1 = sb[0].d1;
    end
    ha = 0; da = 0; hb = 0; db = 0;
    foreach (sb[i]) begin
      if (i_fwd_rs_a != 0 && sb[i].v0 && sb[i].we0 && sb[i].rd0 == i_fwd_rs_a) begin ha = 1; da = sb[i].d0; end
      if (i_fwd_rs_a != 0 && sb[i].v1 && sb[i].we1 && sb[i].rd1 == i_fwd_rs_a) begin ha = 1; da = sb[i].d1; end
      if (i_fwd_rs_b != 0 && sb[i].v0 && sb[i].we0 && sb[i].rd0 == i_fwd_rs_b) begin hb = 1; db = sb[i].d0; end
      if (i_fwd_rs_b != 0 && sb[i].v1 && sb[i].we1 && sb[i].rd1 == i_fwd_rs_b) begin hb = 1; db = sb[i].d1; end
    end
    chk({tag, ".count"}, 32'(o_count), 32'(sb.size()));
    chk({tag, ".ready"}, 32'(o_buff_ready), 32'(sb.size() < DEPTH));
    chk({tag, ".wb_valid"}, 32'(o_wb_valid), 32'(sb.size() > 0));
    chk({tag, ".en0"}, 32'(o_wb_en0), 32'(en0));
    chk({tag, ".rd0"}, 32'(o_wb_rd0), 32'(rd0));
    chk({tag, ".data0"}, o_wb_data0, d0);
    chk({tag, ".en1"}, 32'(o_wb_en1), 32'(en1));
    chk({tag, ".rd1"}, 32'(o_wb_rd1), 32'(rd1));
    chk({tag, ".data1"}, o_wb_data1, d1);
    chk({tag, ".hit_a"}, 32'(o_fwd_hit_a), 32'(ha));
    chk({tag, ".fwd_a"}, o_fwd_data_a, da);
    chk({tag, ".hit_b"}, 32'(o_fwd_hit_b), 32'(hb));
    chk({tag, ".fwd_b"}, o_fwd_data_b, db);
  endtask

  // One clock: drive, check current state, update scoreboard, advance.
  task automatic cyc(input uv_buff_t u, input uv_buff_t v, input logic wbr, input logic fl,
                     input logic rst, input logic [4:0] ra, input logic [4:0] rb,
                     input string tag);
    logic push, pop;
    i_u_pkg = u; i_v_pkg = v; i_wb_ready = wbr; i_flush = fl; i_rst = rst;
    i_fwd_rs_a = ra; i_fwd_rs_b = rb;
    #1;
    check_outputs(tag);
    push = (u.valid | v.valid) && (sb.size() < DEPTH) && !fl;
    pop  = (sb.size() > 0) && wbr;
    if (rst || fl) sb.delete();
    else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back(order(u, v));
    end
    @(posedge i_clk);
    #2;
  endtask

  uv_buff_t z;

  initial begin
    z = '0;
    i_u_pkg = z; i_v_pkg = z; i_wb_ready = 0; i_flush = 0; i_rst = 1;
    i_fwd_rs_a = 0; i_fwd_rs_b = 0;
    @(posedge i_clk); @(posedge i_clk); #2;
    i_rst = 0;

    cyc(z, z, 0, 0, 0, 5, 6, "reset");

    // single push/pop
    cyc(mk(1,1,5,32'h11,0), mk(1,1,6,32'h22,1), 1, 0, 0, 5, 6, "single_push");
    cyc(z, z, 1, 0, 0, 5, 6, "single_head");
    cyc(z, z, 1, 0, 0, 5, 6, "single_empty");

    // swap and collision
    cyc(mk(1,1,7,32'hA,1), mk(1,1,7,32'hB,0), 0, 0, 0, 7, 0, "swap_push");
    cyc(z, z, 1, 0, 0, 7, 7, "swap_head");
    cyc(z, z, 1, 0, 0, 7, 7, "swap_empty");

    // fill and stall, then drain
    for (int i = 0; i < 5; i++)
      cyc(mk(1,1,5'(i+1),32'h1000+i,0), mk(1,1,5'(i+9),32'h2000+i,0), 0, 0, 0,
          5'(i+1), 5'(i+8), $sformatf("fill%0d", i));
    for (int i = 0; i < 5; i++)
      cyc(z, z, 1, 0, 0, 5'(i+1), 9, $sformatf("drain%0d", i));

    // forwarding priority, rd=0 never hits, single-slot and no-write entries
    cyc(mk(1,1,3,32'h100,0), z, 0, 0, 0, 3, 0, "fwd_e0");
    cyc(mk(1,1,3,32'h200,0), mk(1,1,3,32'h300,1), 0, 0, 0, 3, 0, "fwd_e1");
    cyc(z, mk(1,1,0,32'h55,0), 0, 0, 0, 3, 0, "fwd_e2");
    cyc(mk(1,0,3,32'h77,0), z, 0, 0, 0, 3, 0, "fwd_full");
    cyc(z, z, 0, 0, 0, 3, 0, "fwd_check");
    cyc(z, z, 1, 0, 0, 3, 3, "fwd_pop0");
    cyc(z, z, 1, 0, 0, 3, 0, "fwd_pop1");
    cyc(z, z, 1, 0, 0, 3, 0, "fwd_pop2");
    cyc(z, z, 1, 0, 0, 3, 0, "fwd_pop3");

    // flush during push
    cyc(mk(1,1,4,32'h44,0), mk(1,1,8,32'h88,0), 0, 0, 0, 4, 8, "fl_a");
    cyc(mk(1,1,9,32'h99,0), mk(1,1,10,32'hAA,0), 0, 0, 0, 4, 9, "fl_b");
    cyc(mk(1,1,4,32'h45,0), mk(1,1,11,32'hBB,0), 1, 1, 0, 4, 11, "fl_push");
    cyc(z, z, 0, 0, 0, 4, 11, "fl_after");

    // reset mid-operation
    for (int i = 0; i < 3; i++)
      cyc(mk(1,1,5'(i+12),32'hC0+i,0), mk(1,1,5'(i+20),32'hD0+i,0), 0, 0, 0,
          12, 20, $sformatf("rst_fill%0d", i));
    cyc(mk(1,1,1,32'h1,0), z, 1, 0, 1, 12, 20, "rst_pulse");
    cyc(z, z, 0, 0, 0, 12, 20, "rst_after");

    // randomized traffic
    for (int i = 0; i < 300; i++)
      cyc(mk(1'($urandom), 1'($urandom), 5'($urandom_range(0,7)), $urandom, 1'($urandom)),
          mk(1'($urandom), 1'($urandom), 5'($urandom_range(0,7)), $urandom, 1'($urandom)),
          1'($urandom_range(0,3) != 0), 1'($urandom_range(0,19) == 0), 0,
          5'($urandom_range(0,7)), 5'($urandom_range(0,7)), $sformatf("rnd%0d", i));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
